// File: rtl/crc_frame_ctrl_if.sv
// Byte stream handshakes and external CRC engine hookup for crc_frame_ctrl.
interface crc_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       crc_init;
  logic       crc_en;
  logic [7:0] crc_din;
  logic [7:0] crc_val;

  modport master (
    input  rx_data, rx_valid, tx_ready, crc_val,
    output rx_ready, tx_data, tx_valid, crc_init, crc_en, crc_din
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, crc_val,
    input  rx_ready, tx_data, tx_valid, crc_init, crc_en, crc_din
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Frame controller: forwards payload bytes, drives an external CRC engine,
// then appends the CRC byte. Inter-byte timeout aborts a partial frame.
module crc_frame_ctrl #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              frame_len,
  crc_frame_ctrl_if.master        bus,
  output logic                    busy,
  output logic [3:0]              byte_cnt,
  output logic                    frame_done,
  output logic                    err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_FWD, S_CRC_WAIT, S_SEND_CRC, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic rx_rdy;
  logic accept;

  always_comb begin
    rx_rdy = !rst && ((state_q == S_IDLE) || (state_q == S_RECV));
    accept = rx_rdy && bus.rx_valid;
  end

  assign bus.rx_ready = rx_rdy;
  assign bus.crc_en   = accept;
  assign bus.crc_din  = accept ? bus.rx_data : '0;
  assign bus.crc_init = !rst && (state_q == S_IDLE) && !accept;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign byte_cnt     = byte_cnt_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    tx_data_d    = tx_data_q;
    tmo_d        = tmo_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d      = frame_len;
          byte_cnt_d = 4'd1;
          tx_data_d  = bus.rx_data;
          state_d    = S_FWD;
        end
      end
      S_RECV: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          tx_data_d  = bus.rx_data;
          tmo_d      = '0;
          state_d    = S_FWD;
        end else if (tmo_q == TMO_LAST) begin
          err_d      = 1'b1;
          byte_cnt_d = '0;
          tmo_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FWD: begin
        tmo_d = '0;
        // Length 0 encodes 16; the 4-bit count wraps to 0 on the 16th byte,
        // so a raw 4-bit equality covers both cases.
        if (bus.tx_ready) state_d = (byte_cnt_q == len_q) ? S_CRC_WAIT : S_RECV;
      end
      S_CRC_WAIT: begin
        tx_data_d = bus.crc_val;
        state_d   = S_SEND_CRC;
      end
      S_SEND_CRC: begin
        if (bus.tx_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    tx_valid_d = (state_d == S_FWD) || (state_d == S_SEND_CRC);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
module tb_crc_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] frame_len;
  logic       busy;
  logic [3:0] byte_cnt;
  logic       frame_done;
  logic       err;

  crc_frame_ctrl_if bus();

  crc_frame_ctrl #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .frame_len(frame_len), .bus(bus),
    .busy(busy), .byte_cnt(byte_cnt), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // External CRC engine model: CRC-8, poly 0x07, seed 0x00, registered result.
  logic [7:0] crc_reg;
  always @(posedge clk) begin
    if (rst || bus.crc_init) crc_reg <= 8'h00;
    else if (bus.crc_en)     crc_reg <= crc8(crc_reg, bus.crc_din);
  end
  assign bus.crc_val = crc_reg;

  // Monitor: collects tx handshakes, counts pulses, tallies per-cycle violations.
  logic [7:0] txq[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         viol     = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
      if (frame_done) done_cnt++;
      if (err) err_cnt++;
      if (bus.crc_init && bus.crc_en) viol++;
      if (bus.rx_valid && bus.rx_ready && (!bus.crc_en || bus.crc_din !== bus.rx_data)) viol++;
      if (stall_prev && (!bus.tx_valid || bus.tx_data !== data_prev)) viol++;
      stall_prev = bus.tx_valid && !bus.tx_ready;
      data_prev  = bus.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    bus.rx_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_byte_accept: byte %02h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic wait_frames(input int target, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    frame_len = 4'd0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      failures++; $display("FAIL reset_rx_ready: got %b expected 0", bus.rx_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.crc_init, bus.tx_valid, bus.crc_en} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_ctrl: got rx_ready,crc_init,tx_valid,crc_en=%b expected 1100",
               {bus.rx_ready, bus.crc_init, bus.tx_valid, bus.crc_en});
    end
    checks++;
    if ({bus.tx_data, bus.crc_din} !== 16'h0000) begin
      failures++; $display("FAIL reset_data: got tx_data,crc_din=%04h expected 0000", {bus.tx_data, bus.crc_din});
    end
    checks++;
    if ({busy, byte_cnt, frame_done, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_status: got busy,byte_cnt,frame_done,err=%b expected 0000000", {busy, byte_cnt, frame_done, err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int         base, d0, e0;
    logic       ok;
    logic [7:0] exp_s[10];
    for (int i = 0; i < 9; i++) exp_s[i] = 8'h31 + 8'(i);
    exp_s[9] = 8'hF4;
    base = txq.size(); d0 = done_cnt; e0 = err_cnt;
    bus.tx_ready = 1'b1;
    frame_len = 4'd9;
    send_byte(8'h31);
    frame_len = 4'd2;
    @(negedge clk);
    checks++;
    if ({bus.tx_valid, bus.tx_data, byte_cnt, busy} !== {1'b1, 8'h31, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL basic_first_latency: got valid=%b data=%02h cnt=%0d busy=%b expected 1 31 1 1",
               bus.tx_valid, bus.tx_data, byte_cnt, busy);
    end
    for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i));
    wait_frames(d0 + 1, ok);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != d0 + 1) begin
      failures++; $display("FAIL basic_frame_done: got %0d pulses expected 1", done_cnt - d0);
    end
    checks++;
    if (txq.size() != base + 10) begin
      failures++; $display("FAIL basic_stream_len: got %0d expected 10", txq.size() - base);
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (txq[base + i] !== exp_s[i]) begin
          failures++; $display("FAIL basic_stream[%0d]: got %02h expected %02h", i, txq[base + i], exp_s[i]);
        end
      end
    end
    checks++;
    if (err_cnt != e0 || busy !== 1'b0 || byte_cnt !== 4'd0) begin
      failures++;
      $display("FAIL basic_end_state: got errs=%0d busy=%b cnt=%0d expected 0 0 0", err_cnt - e0, busy, byte_cnt);
    end
  endtask

  task automatic test_stall;
    int   base, d0, n;
    logic ok;
    base = txq.size(); d0 = done_cnt;
    bus.tx_ready = 1'b0;
    frame_len = 4'd1;
    send_byte(8'h00);
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx_valid, bus.tx_data, bus.rx_ready, bus.crc_en} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_payload[%0d]: got valid=%b data=%02h rx_ready=%b crc_en=%b expected 1 00 0 0",
                 k, bus.tx_valid, bus.tx_data, bus.rx_ready, bus.crc_en);
      end
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); ok = bus.tx_valid;
      if (!ok) begin @(posedge clk); #1; end
      n++;
    end while (!ok && n < 10);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL stall_crc_valid: got tx_valid=0 after %0d cycles expected 1", n);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.tx_valid, bus.tx_data, bus.rx_ready} !== {1'b1, 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL stall_crc[%0d]: got valid=%b data=%02h rx_ready=%b expected 1 00 0",
                 k, bus.tx_valid, bus.tx_data, bus.rx_ready);
      end
    end
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_frames(d0 + 1, ok);
    checks++;
    if (!ok || txq.size() != base + 2 || txq[base] !== 8'h00 || txq[base + 1] !== 8'h00) begin
      failures++; $display("FAIL stall_stream: got %0d bytes expected 2 bytes 00 00", txq.size() - base);
    end
  endtask

  task automatic test_len16;
    int         base, d0;
    logic       ok;
    logic [7:0] c;
    base = txq.size(); d0 = done_cnt;
    bus.tx_ready = 1'b1;
    frame_len = 4'd0;
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      c = crc8(c, 8'(i));
      if (i == 14) begin
        checks++;
        if (byte_cnt !== 4'd15) begin
          failures++; $display("FAIL len16_cnt15: got %0d expected 15", byte_cnt);
        end
      end
    end
    checks++;
    if (byte_cnt !== 4'd0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0F) begin
      failures++;
      $display("FAIL len16_wrap: got cnt=%0d valid=%b data=%02h expected 0 1 0f", byte_cnt, bus.tx_valid, bus.tx_data);
    end
    wait_frames(d0 + 1, ok);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (!ok || done_cnt != d0 + 1 || txq.size() != base + 17) begin
      failures++;
      $display("FAIL len16_frame: got done=%0d bytes=%0d expected 1 17", done_cnt - d0, txq.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (txq[base + i] !== 8'(i)) begin
          failures++; $display("FAIL len16_stream[%0d]: got %02h expected %02h", i, txq[base + i], 8'(i));
        end
      end
      checks++;
      if (txq[base + 16] !== c) begin
        failures++; $display("FAIL len16_crc: got %02h expected %02h", txq[base + 16], c);
      end
    end
  endtask

  task automatic test_timeout;
    int base, d0, e0, first;
    base = txq.size(); d0 = done_cnt; e0 = err_cnt;
    bus.tx_ready = 1'b1;
    frame_len = 4'd4;
    send_byte(8'hA1);
    send_byte(8'hA2);
    first = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (err && first < 0) begin
        first = j;
        checks++;
        if (busy !== 1'b0 || byte_cnt !== 4'd0) begin
          failures++; $display("FAIL timeout_state: got busy=%b cnt=%0d expected 0 0", busy, byte_cnt);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (first != 21) begin
      failures++; $display("FAIL timeout_latency: got err at cycle %0d expected 21", first);
    end
    checks++;
    if (err_cnt != e0 + 1 || done_cnt != d0 || txq.size() != base + 2) begin
      failures++;
      $display("FAIL timeout_abort: got errs=%0d done=%0d bytes=%0d expected 1 0 2",
               err_cnt - e0, done_cnt - d0, txq.size() - base);
    end
  endtask

  task automatic test_reset_in_send;
    int   d0, n;
    logic ok;
    d0 = done_cnt;
    bus.tx_ready = 1'b0;
    frame_len = 4'd1;
    send_byte(8'h55);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); ok = bus.tx_valid;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 10);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_send_reach: got tx_valid=0 after %0d cycles expected 1", n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.tx_valid, busy, bus.crc_init, byte_cnt} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL rst_send_state: got valid=%b busy=%b crc_init=%b cnt=%0d expected 0 0 1 0",
               bus.tx_valid, busy, bus.crc_init, byte_cnt);
    end
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done_cnt != d0) begin
      failures++; $display("FAIL rst_send_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    rst          = 1'b1;
    frame_len    = 4'd0;
    test_reset();
    test_basic();
    test_stall();
    test_len16();
    test_timeout();
    test_basic();
    test_reset_in_send();
    test_basic();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 50000, max idle cycles between received bytes inside a frame (1 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 frame_len  input  4  payload bytes per frame; sampled at first byte accept; 0 means 16.
REQ-005 rx_data  input  8  payload byte from UART receiver.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  controller accepts a byte this cycle.
REQ-008 tx_data  output  8  byte to UART transmitter.
REQ-009 tx_valid  output  1  tx_data valid; held until tx_ready.
REQ-010 tx_ready  input  1  transmitter takes tx_data this cycle.
REQ-011 crc_init  output  1  load seed into external CRC engine.
REQ-012 crc_en  output  1  engine absorbs crc_din this cycle.
REQ-013 crc_din  output  8  byte fed to engine.
REQ-014 crc_val  input  8  engine registered CRC result.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 byte_cnt  output  4  payload bytes accepted in current frame (mod 16).
REQ-017 frame_done  output  1  one-cycle pulse after CRC byte handshake.
REQ-018 err  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-019 States: IDLE, RECV, FWD, CRC_WAIT, SEND_CRC, DONE; one-hot or binary, implementer's choice.
REQ-020 Accept = rx_valid & rx_ready; rx_ready = 1 only in IDLE and RECV.
REQ-021 On accept: crc_en = 1, crc_din = rx_data (combinational, same cycle); rx_data latched to tx_data; byte_cnt increments; next state FWD.
REQ-022 Accept in IDLE also latches frame_len (0 -> 16) into internal length register, byte_cnt becomes 1.
REQ-023 crc_init = 1 in IDLE in any cycle without accept, else 0; crc_init and crc_en never both 1.
REQ-024 FWD: tx_valid = 1, tx_data stable; on tx_ready -> RECV if byte_cnt < length, else CRC_WAIT; length 16 is reached when byte_cnt wraps to 0 after 16 accepts.
REQ-025 Latency: accept at cycle N -> tx_valid = 1 at N+1; tx_ready at same cycle completes it (no bubble required beyond state change).
REQ-026 CRC_WAIT: exactly one cycle, tx_valid = 0, lets engine output settle; -> SEND_CRC.
REQ-027 SEND_CRC: tx_valid = 1, tx_data = crc_val captured on entry; on tx_ready -> DONE.
REQ-028 DONE: frame_done = 1 for one cycle, byte_cnt cleared, -> IDLE.
REQ-029 RECV timeout counter: cleared on entry to RECV and on each accept; if counter reaches TIMEOUT-1 without accept -> err = 1 one cycle, byte_cnt cleared, -> IDLE (no CRC byte sent).
REQ-030 No timeout in IDLE, FWD or SEND_CRC; tx backpressure may stall indefinitely.
REQ-031 rx_valid in FWD/CRC_WAIT/SEND_CRC/DONE ignored (rx_ready = 0); byte must be held by source.
REQ-032 Accept and timeout in same cycle: accept wins, no err.
REQ-033 frame_len changes mid-frame have no effect until next frame.

Reset
REQ-034 rst high at any edge -> IDLE next cycle, mid-frame included; partial frame discarded.
REQ-035 Reset values: rx_ready 0 during rst then 1 in IDLE, tx_valid 0, tx_data 0x00, crc_en 0, crc_din 0x00, crc_init 1 after rst released, busy 0, byte_cnt 0, frame_done 0, err 0, timeout counter 0.

Verification (engine model: CRC-8, poly 0x07, seed 0x00)
REQ-036 frame_len 9, send 0x31..0x39, tx_ready always 1 -> tx stream 0x31..0x39 then 0xF4; frame_done one pulse; err never.
REQ-037 frame_len 1, byte 0x00, tx_ready low 5 cycles on each byte -> tx_valid held stable, stream 0x00, 0x00; rx_ready 0 during stall.
REQ-038 frame_len 0, 16 bytes 0x00..0x0F -> 16 payload bytes forwarded then CRC byte; byte_cnt wraps 15 -> 0; exactly one frame_done.
REQ-039 TIMEOUT 20, frame_len 4, send 2 bytes then idle -> err pulse 20 cycles after entering RECV, no CRC byte, next frame CRC correct (seed reloaded).
REQ-040 rst asserted while in SEND_CRC -> next cycle tx_valid 0, busy 0, crc_init 1; following frame_len 9 frame again yields 0xF4.
REQ-041 Every cycle: assert !(crc_init & crc_en), tx_data stable while tx_valid & !tx_ready.
